// File: rtl/dpram_stream_rd_if.sv
// Write port and valid/ready read port of dpram_stream_rd.
// master drives writes, read requests and response ready; slave is the RAM block.
interface dpram_stream_rd_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 16
);
    logic            ena;
    logic [DW/8-1:0] wea;
    logic [AW-1:0]   addra;
    logic [DW-1:0]   dia;
    logic            rd_req_valid;
    logic            rd_req_ready;
    logic [AW-1:0]   rd_addr;
    logic            rd_rsp_valid;
    logic            rd_rsp_ready;
    logic [DW-1:0]   rd_rsp_data;
    logic            rd_busy;

    modport master (
        output ena, wea, addra, dia, rd_req_valid, rd_addr, rd_rsp_ready,
        input  rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_busy
    );

    modport slave (
        input  ena, wea, addra, dia, rd_req_valid, rd_addr, rd_rsp_ready,
        output rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_busy
    );
endinterface

// File: rtl/dpram_stream_rd.sv
// Dual-port buffer RAM with byte-lane writes and a credit-limited valid/ready read port.
// Reads pass a fixed N_DELAY pipeline into a skid FIFO sized so backpressure never drops data.
module dpram_stream_rd #(
    parameter int unsigned DW         = 32,
    parameter int unsigned AW         = 16,
    parameter int unsigned DEPTH      = 1 << AW,
    parameter int unsigned N_DELAY    = 1,
    parameter int unsigned SKID_DEPTH = N_DELAY + 2,
    parameter bit          FWD        = 1'b1
) (
    input logic              clk,
    input logic              rst,
    dpram_stream_rd_if.slave bus
);
    localparam int unsigned NumBytes = DW / 8;
    localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PtrW     = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int unsigned CntW     = $clog2(SKID_DEPTH + 1);
    localparam logic [AW:0]      DepthW  = (AW + 1)'(DEPTH);
    localparam logic [CntW-1:0]  CredMax = CntW'(SKID_DEPTH);
    localparam logic [PtrW-1:0]  PtrLast = PtrW'(SKID_DEPTH - 1);

    logic            accept, pop, wr_ok, rd_ok;
    logic [IdxW-1:0] wr_idx, rd_idx;
    logic [DW-1:0]   fwd_mask;

    assign accept = bus.rd_req_valid & bus.rd_req_ready;
    assign pop    = bus.rd_rsp_valid & bus.rd_rsp_ready;
    assign wr_ok  = bus.ena & ({1'b0, bus.addra} < DepthW);
    assign rd_ok  = {1'b0, bus.rd_addr} < DepthW;
    assign wr_idx = bus.addra[IdxW-1:0];
    assign rd_idx = bus.rd_addr[IdxW-1:0];

    always_comb begin
        fwd_mask = '0;
        if (FWD && bus.ena && rd_ok && (bus.addra == bus.rd_addr)) begin
            for (int i = 0; i < NumBytes; i++) begin
                fwd_mask[8*i +: 8] = {8{bus.wea[i]}};
            end
        end
    end

    // RAM array and read-stage capture; the read sees the pre-write word (read-first).
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ram_q, fwd_data_q, fwd_mask_q;
    logic          zero_q, vld0_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NumBytes; i++) begin
            if (wr_ok && bus.wea[i]) begin
                mem[wr_idx][8*i +: 8] <= bus.dia[8*i +: 8];
            end
        end
        if (accept) begin
            ram_q      <= mem[rd_idx];
            fwd_data_q <= bus.dia;
            fwd_mask_q <= fwd_mask;
            zero_q     <= ~rd_ok;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld0_q <= 1'b0;
        end else begin
            vld0_q <= accept;
        end
    end

    logic [DW-1:0] merged, out_data;
    logic          out_vld;

    assign merged = zero_q ? '0 : ((ram_q & ~fwd_mask_q) | (fwd_data_q & fwd_mask_q));

    if (N_DELAY == 1) begin : g_nodly
        assign out_vld  = vld0_q;
        assign out_data = merged;
    end else begin : g_dly
        logic [DW-1:0]        dly_q [N_DELAY-1];
        logic [N_DELAY-2:0]   dvld_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dvld_q <= '0;
            end else begin
                dvld_q[0] <= vld0_q;
                for (int k = 1; k < N_DELAY - 1; k++) begin
                    dvld_q[k] <= dvld_q[k-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            dly_q[0] <= merged;
            for (int k = 1; k < N_DELAY - 1; k++) begin
                dly_q[k] <= dly_q[k-1];
            end
        end

        assign out_vld  = dvld_q[N_DELAY-2];
        assign out_data = dly_q[N_DELAY-2];
    end

    // Skid FIFO; credits guarantee a free slot whenever out_vld is set.
    logic [DW-1:0]   fifo_q [SKID_DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d, credits_q, credits_d;

    always_ff @(posedge clk) begin
        if (out_vld) begin
            fifo_q[wptr_q] <= out_data;
        end
    end

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        credits_d = credits_q;
        if (out_vld) begin
            wptr_d = (wptr_q == PtrLast) ? '0 : wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = (rptr_q == PtrLast) ? '0 : rptr_q + 1'b1;
        end
        case ({out_vld, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        case ({accept, pop})
            2'b10:   credits_d = credits_q - 1'b1;
            2'b01:   credits_d = credits_q + 1'b1;
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            credits_q <= CredMax;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            credits_q <= credits_d;
        end
    end

    assign bus.rd_req_ready = (credits_q != '0);
    assign bus.rd_rsp_valid = (count_q != '0);
    assign bus.rd_rsp_data  = bus.rd_rsp_valid ? fifo_q[rptr_q] : '0;
    assign bus.rd_busy      = (credits_q != CredMax);
endmodule

// File: tb/tb_dpram_stream_rd.sv
// Drives three dpram_stream_rd variants with shared stimulus and checks each against
// a queue-based response model derived from the block's read/write/credit rules.
module tb_dpram_stream_rd;
    typedef struct {
        logic [31:0] data;
        int unsigned t;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [3:0]  wea;
    logic [11:0] addra;
    logic [31:0] dia;
    logic        rd_req_valid;
    logic [11:0] rd_addr;
    logic        rd_rsp_ready;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_rst(input string tag, input logic v, input logic r, input logic b,
                             input logic [31:0] d);
        check({tag, " rst valid"}, 32'(v), 32'd0);
        check({tag, " rst ready"}, 32'(r), 32'd1);
        check({tag, " rst busy"},  32'(b), 32'd0);
        check({tag, " rst data"},  d, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Variants: (N_DELAY, FWD, DEPTH) = (1,1,4096), (2,1,1536), (3,0,4096)
    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int unsigned NDL = g + 1;
        localparam bit          FW  = (g == 2) ? 1'b0 : 1'b1;
        localparam int unsigned DEP = (g == 1) ? 1536 : 4096;
        localparam int unsigned SK  = NDL + 2;

        dpram_stream_rd_if #(.DW(32), .AW(12)) u_bus ();

        assign u_bus.ena          = ena;
        assign u_bus.wea          = wea;
        assign u_bus.addra        = addra;
        assign u_bus.dia          = dia;
        assign u_bus.rd_req_valid = rd_req_valid;
        assign u_bus.rd_addr      = rd_addr;
        assign u_bus.rd_rsp_ready = rd_rsp_ready;

        dpram_stream_rd #(
            .DW(32), .AW(12), .DEPTH(DEP), .N_DELAY(NDL), .SKID_DEPTH(SK), .FWD(FW)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(u_bus)
        );

        logic [31:0] mem_m [4096];
        rsp_t        q[$];
        rsp_t        r;
        int unsigned cyc = 0;
        logic        e_rdy, e_vld;
        logic [31:0] e_dat, rd;
        string       tg;

        // Outstanding = accepted and not yet popped; response visible from accept+N+1.
        always @(negedge clk) begin
            tg = $sformatf("i%0d", g);
            if (rst) begin
                q.delete();
                check_rst(tg, u_bus.rd_rsp_valid, u_bus.rd_req_ready, u_bus.rd_busy,
                          u_bus.rd_rsp_data);
            end else begin
                e_rdy = (q.size() < int'(SK));
                e_vld = (q.size() != 0) && (q[0].t <= cyc);
                e_dat = e_vld ? q[0].data : 32'd0;
                check({tg, " ready"}, 32'(u_bus.rd_req_ready), 32'(e_rdy));
                check({tg, " valid"}, 32'(u_bus.rd_rsp_valid), 32'(e_vld));
                check({tg, " data"},  u_bus.rd_rsp_data, e_dat);
                check({tg, " busy"},  32'(u_bus.rd_busy), 32'(q.size() != 0));
                if (e_vld && rd_rsp_ready) begin
                    void'(q.pop_front());
                end
                if (rd_req_valid && e_rdy) begin
                    rd = (int'(rd_addr) < int'(DEP)) ? mem_m[rd_addr] : 32'd0;
                    if (FW && ena && (addra == rd_addr) && (int'(rd_addr) < int'(DEP))) begin
                        for (int i = 0; i < 4; i++) begin
                            if (wea[i]) rd[8*i +: 8] = dia[8*i +: 8];
                        end
                    end
                    r.data = rd;
                    r.t    = cyc + NDL + 1;
                    q.push_back(r);
                end
                if (ena && (int'(addra) < int'(DEP))) begin
                    for (int i = 0; i < 4; i++) begin
                        if (wea[i]) mem_m[addra][8*i +: 8] = dia[8*i +: 8];
                    end
                end
            end
            cyc++;
        end
    end

    initial begin
        rst          = 1'b1;
        ena          = 1'b0;
        wea          = 4'h0;
        addra        = '0;
        dia          = '0;
        rd_req_valid = 1'b0;
        rd_addr      = '0;
        rd_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        tick();

        // Fill every address so the model never holds unknown words.
        for (int a = 0; a < 4096; a++) begin
            ena = 1'b1; wea = 4'hF; addra = 12'(a); dia = $urandom;
            tick();
        end

        // Basic write then read of addr 5.
        addra = 12'd5; dia = 32'h1122_3344; wea = 4'hF;
        tick();
        ena = 1'b0; rd_req_valid = 1'b1; rd_addr = 12'd5;
        tick();
        rd_req_valid = 1'b0;
        repeat (6) tick();

        // Byte-lane merge with same-cycle read, then a later read.
        ena = 1'b1; wea = 4'hF; addra = 12'd7; dia = 32'hAABB_CCDD;
        tick();
        wea = 4'b0001; dia = 32'h0000_0055; rd_req_valid = 1'b1; rd_addr = 12'd7;
        tick();
        ena = 1'b0;
        tick();
        rd_req_valid = 1'b0;
        repeat (8) tick();

        // Backpressure: requests to 0..9 with the consumer stalled.
        rd_rsp_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rd_req_valid = 1'b1; rd_addr = 12'(i);
            tick();
        end
        rd_req_valid = 1'b0;
        repeat (3) tick();
        rd_rsp_ready = 1'b1;
        repeat (10) tick();

        // Streaming back-to-back reads.
        for (int i = 0; i < 256; i++) begin
            rd_req_valid = 1'b1; rd_addr = 12'($urandom_range(0, 4095));
            tick();
        end
        rd_req_valid = 1'b0;
        repeat (8) tick();

        // Out-of-range write/read for the 1536-deep variant, plus its last word.
        ena = 1'b1; wea = 4'hF; addra = 12'd1600; dia = 32'hDEAD_BEEF;
        tick();
        ena = 1'b0; rd_req_valid = 1'b1; rd_addr = 12'd1600;
        tick();
        rd_addr = 12'd1535;
        tick();
        rd_req_valid = 1'b0;
        repeat (8) tick();

        // Random traffic concentrated on a few addresses and the 1536 boundary.
        for (int i = 0; i < 3000; i++) begin
            ena          = ($urandom_range(0, 1) == 1);
            wea          = 4'($urandom_range(0, 15));
            addra        = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(1530, 1610))
                                                       : 12'($urandom_range(0, 15));
            dia          = $urandom;
            rd_req_valid = ($urandom_range(0, 3) != 0);
            rd_addr      = ($urandom_range(0, 1) == 0) ? addra
                                                       : 12'($urandom_range(0, 15));
            rd_rsp_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        ena = 1'b0; rd_req_valid = 1'b0; rd_rsp_ready = 1'b1;
        repeat (12) tick();

        // Reset with reads in flight and responses queued.
        rd_rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rd_req_valid = 1'b1; rd_addr = 12'(i + 20);
            tick();
        end
        rd_req_valid = 1'b0;
        check("i2 busy before rst", 32'(g_inst[2].u_bus.rd_busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_rst("i0 async", g_inst[0].u_bus.rd_rsp_valid, g_inst[0].u_bus.rd_req_ready,
                  g_inst[0].u_bus.rd_busy, g_inst[0].u_bus.rd_rsp_data);
        check_rst("i1 async", g_inst[1].u_bus.rd_rsp_valid, g_inst[1].u_bus.rd_req_ready,
                  g_inst[1].u_bus.rd_busy, g_inst[1].u_bus.rd_rsp_data);
        check_rst("i2 async", g_inst[2].u_bus.rd_rsp_valid, g_inst[2].u_bus.rd_req_ready,
                  g_inst[2].u_bus.rd_busy, g_inst[2].u_bus.rd_rsp_data);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        rd_rsp_ready = 1'b1;
        repeat (10) tick();
        rd_req_valid = 1'b1; rd_addr = 12'd3;
        tick();
        rd_req_valid = 1'b0;
        repeat (8) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
